// File: rtl/lcd_driver_pkg.sv
// Shared definitions for the HD44780 character LCD driver.
// Holds the controller state encodings, LCD bus transfer phases, LCD command
// bytes, the CPU/ALU opcode encodings and the mnemonic character table.
// Optional feature macro: LCD_DRIVER_HEX_EN adds the hex nibble-to-ASCII helper.
package lcd_driver_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_CONVERT,
    ST_WRITE,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_PULSE,
    PH_HOLD,
    PH_WAIT
  } phase_t;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SUBI = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_DPL  = 3'b111;

  localparam logic [7:0] CH_SPACE = 8'h20;

  function automatic logic [31:0] mnemonic(input logic [2:0] op);
    case (op)
      OP_LOAD: return "LOAD";
      OP_ADD:  return "ADD ";
      OP_ADDI: return "ADDI";
      OP_SUB:  return "SUB ";
      OP_SUBI: return "SUBI";
      OP_MUL:  return "MUL ";
      OP_CLR:  return "CLR ";
      default: return "DPL ";
    endcase
  endfunction

  function automatic logic [7:0] mnemonic_char(input logic [2:0] op, input logic [1:0] pos);
    logic [31:0] s;
    s = mnemonic(op);
    case (pos)
      2'd0:    return s[31:24];
      2'd1:    return s[23:16];
      2'd2:    return s[15:8];
      default: return s[7:0];
    endcase
  endfunction

`ifdef LCD_DRIVER_HEX_EN
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
  endfunction
`endif

endpackage

// File: rtl/lcd_driver_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, 16-bit binary to 5 BCD digits.
// Ports: clk, rst_n (async active-low), start (loads bin, begins conversion),
//        bin[15:0], ready (high when idle / result valid), bcd[19:0] (digit 4 in MSBs).
// One shift per cycle; ready returns high 16 cycles after start.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        ready,
  output logic [19:0] bcd
);

  logic [15:0] shreg;
  logic [19:0] acc;
  logic [19:0] adj;
  logic [4:0]  cnt;

  always_comb begin
    adj = acc;
    for (int unsigned i = 0; i < 5; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (start) begin
      shreg <= bin;
      acc   <= '0;
      cnt   <= 5'd16;
    end else if (cnt != 5'd0) begin
      acc   <= {adj[18:0], shreg[15]};
      shreg <= {shreg[14:0], 1'b0};
      cnt   <= cnt - 5'd1;
    end
  end

  assign ready = (cnt == 5'd0);
  assign bcd   = acc;

endmodule

// File: rtl/lcd_driver.sv
// lcd_driver: HD44780 16x2 LCD driver rendering "mnemonic [reg]" on line 1 and the
// signed decimal result on line 2. Owns power-up init, conversion and bus timing.
// Ports: clk, rst_n (async active-low), req/opcode/reg_addr/value (display request),
//        busy, done (one-cycle completion pulse), lcd_rs, lcd_rw (always 0),
//        lcd_en, lcd_data[7:0] (8-bit bus).
// Optional feature macro: LCD_DRIVER_HEX_EN shows "0x" + 4 hex digits on line 2 cols 0-5.
module lcd_driver
  import lcd_driver_pkg::*;
#(
  parameter int unsigned EN_CYCLES      = 12,
  parameter int unsigned WAIT_CYCLES    = 2500,
  parameter int unsigned CLEAR_CYCLES   = 100000,
  parameter int unsigned POWERUP_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [2:0]  opcode,
  input  logic [3:0]  reg_addr,
  input  logic [15:0] value,
  output logic        busy,
  output logic        done,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic [7:0]  lcd_data
);

  localparam int unsigned MAX_A   = (EN_CYCLES > WAIT_CYCLES) ? EN_CYCLES : WAIT_CYCLES;
  localparam int unsigned MAX_B   = (CLEAR_CYCLES > POWERUP_CYCLES) ? CLEAR_CYCLES : POWERUP_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  state_t             state, state_d;
  phase_t             phase, phase_d;
  logic [CNT_W-1:0]   cnt, cnt_d, wait_lim;
  logic [5:0]         idx, idx_d;
  logic               accept, last_xfer, xfer;
  logic [2:0]         op_q;
  logic [3:0]         reg_q;
  logic [15:0]        val_q, mag;
  logic               bcd_ready;
  logic [19:0]        bcd;
  logic [5:0]         pos;
  logic [3:0]         col;
  logic [7:0]         cur_byte;
  logic               cur_rs;

  assign mag = value[15] ? (~value + 16'd1) : value;

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept),
    .bin   (mag),
    .ready (bcd_ready),
    .bcd   (bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_POWERUP_WAIT;
      phase <= PH_SETUP;
      cnt   <= '0;
      idx   <= '0;
      op_q  <= '0;
      reg_q <= '0;
      val_q <= '0;
    end else begin
      state <= state_d;
      phase <= phase_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      if (accept) begin
        op_q  <= opcode;
        reg_q <= reg_addr;
        val_q <= value;
      end
    end
  end

  // INIT and WRITE share one transfer engine; idx selects the byte, and the
  // last transfer of each sequence decides the exit state.
  always_comb begin
    state_d   = state;
    phase_d   = phase;
    cnt_d     = cnt;
    idx_d     = idx;
    accept    = 1'b0;
    last_xfer = (state == ST_INIT) ? (idx == 6'd3) : (idx == 6'd33);
    wait_lim  = (state == ST_INIT && idx == 6'd3) ? CNT_W'(CLEAR_CYCLES) : CNT_W'(WAIT_CYCLES);
    case (state)
      ST_POWERUP_WAIT: begin
        if (cnt == CNT_W'(POWERUP_CYCLES - 1)) begin
          state_d = ST_INIT;
          phase_d = PH_SETUP;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_INIT, ST_WRITE: begin
        case (phase)
          PH_SETUP: begin
            phase_d = PH_PULSE;
            cnt_d   = '0;
          end
          PH_PULSE: begin
            if (cnt == CNT_W'(EN_CYCLES - 1)) begin
              phase_d = PH_HOLD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt + 1'b1;
            end
          end
          PH_HOLD: begin
            phase_d = PH_WAIT;
            cnt_d   = '0;
          end
          default: begin
            if (cnt == wait_lim - 1'b1) begin
              cnt_d   = '0;
              phase_d = PH_SETUP;
              if (last_xfer) begin
                idx_d   = '0;
                state_d = (state == ST_INIT) ? ST_IDLE : ST_DONE;
              end else begin
                idx_d = idx + 6'd1;
              end
            end else begin
              cnt_d = cnt + 1'b1;
            end
          end
        endcase
      end
      ST_IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (bcd_ready) begin
          state_d = ST_WRITE;
          phase_d = PH_SETUP;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_POWERUP_WAIT;
    endcase
  end

  // Byte selection: idx 0 = line-1 address, 1..16 line 1, 17 = line-2 address, 18..33 line 2.
  always_comb begin
    cur_byte = '0;
    cur_rs   = 1'b0;
    pos      = (idx >= 6'd18) ? (idx - 6'd18) : (idx - 6'd1);
    col      = pos[3:0];
    if (state == ST_INIT) begin
      case (idx[1:0])
        2'd0:    cur_byte = CMD_FUNC_SET;
        2'd1:    cur_byte = CMD_DISP_ON;
        2'd2:    cur_byte = CMD_ENTRY;
        default: cur_byte = CMD_CLEAR;
      endcase
    end else if (idx == 6'd0) begin
      cur_byte = CMD_LINE1;
    end else if (idx == 6'd17) begin
      cur_byte = CMD_LINE2;
    end else if (idx <= 6'd16) begin
      cur_rs = 1'b1;
      case (col)
        4'd0, 4'd1, 4'd2, 4'd3: cur_byte = mnemonic_char(op_q, col[1:0]);
        4'd6:    cur_byte = "[";
        4'd7:    cur_byte = {7'h18, reg_q[3]};
        4'd8:    cur_byte = {7'h18, reg_q[2]};
        4'd9:    cur_byte = {7'h18, reg_q[1]};
        4'd10:   cur_byte = {7'h18, reg_q[0]};
        4'd11:   cur_byte = "]";
        default: cur_byte = CH_SPACE;
      endcase
    end else begin
      cur_rs = 1'b1;
      case (col)
`ifdef LCD_DRIVER_HEX_EN
        4'd0:    cur_byte = "0";
        4'd1:    cur_byte = "x";
        4'd2:    cur_byte = hex_char(val_q[15:12]);
        4'd3:    cur_byte = hex_char(val_q[11:8]);
        4'd4:    cur_byte = hex_char(val_q[7:4]);
        4'd5:    cur_byte = hex_char(val_q[3:0]);
`endif
        4'd10:   cur_byte = val_q[15] ? "-" : "+";
        4'd11:   cur_byte = {4'h3, bcd[19:16]};
        4'd12:   cur_byte = {4'h3, bcd[15:12]};
        4'd13:   cur_byte = {4'h3, bcd[11:8]};
        4'd14:   cur_byte = {4'h3, bcd[7:4]};
        4'd15:   cur_byte = {4'h3, bcd[3:0]};
        default: cur_byte = CH_SPACE;
      endcase
    end
  end

  assign xfer     = (state == ST_INIT) || (state == ST_WRITE);
  assign lcd_en   = xfer && (phase == PH_PULSE);
  assign lcd_rs   = xfer && cur_rs;
  assign lcd_data = xfer ? cur_byte : 8'h00;
  assign lcd_rw   = 1'b0;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_lcd_driver.sv
// Self-checking bench for lcd_driver: table of display requests, a transfer
// scoreboard fed at request time, and hand-written init / ignored-req / reset sequences.
module tb_lcd_driver;

  localparam int EN    = 2;
  localparam int WT    = 4;
  localparam int CL    = 8;
  localparam int PU    = 16;
  localparam int XFER  = 2 + EN + WT;
  localparam int LAT   = 1 + 16 + 34 * XFER;
  localparam int NVEC  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [2:0]  opcode = '0;
  logic [3:0]  reg_addr = '0;
  logic [15:0] value = '0;
  logic        busy, done, lcd_rs, lcd_rw, lcd_en;
  logic [7:0]  lcd_data;

  always #5 clk = ~clk;

  lcd_driver #(
    .EN_CYCLES     (EN),
    .WAIT_CYCLES   (WT),
    .CLEAR_CYCLES  (CL),
    .POWERUP_CYCLES(PU)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .opcode   (opcode),
    .reg_addr (reg_addr),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_en   (lcd_en),
    .lcd_data (lcd_data)
  );

  typedef struct {
    logic [2:0]   op;
    logic [3:0]   ra;
    logic [15:0]  val;
    logic [127:0] line1;
    logic [47:0]  tail;
    logic [47:0]  hex;
  } vec_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
  } xfer_t;

  vec_t  vecs[NVEC];
  xfer_t exp_q[$];

  // Bus monitor: records every en-strobe, the HOLD cycle, and done pulses.
  logic       prev_en = 1'b0;
  int         cyc = 0;
  int         first_en = -1;
  int         last_hold = -1;
  int         cap_n = 0;
  int         done_cnt = 0;
  int         stab_bad = 0;
  logic       cap_rs[0:1023];
  logic [7:0] cap_data[0:1023];
  logic       held_rs = 1'b0;
  logic [7:0] held_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en  <= 1'b0;
      cyc      <= 0;
      first_en <= -1;
    end else begin
      cyc     <= cyc + 1;
      prev_en <= lcd_en;
      if (lcd_en && !prev_en) begin
        if (cap_n < 1024) begin
          cap_rs[cap_n]   <= lcd_rs;
          cap_data[cap_n] <= lcd_data;
        end
        cap_n     <= cap_n + 1;
        held_rs   <= lcd_rs;
        held_data <= lcd_data;
        if (first_en < 0) first_en <= cyc;
      end
      if (!lcd_en && prev_en) begin
        last_hold <= cyc;
        if (lcd_data !== held_data || lcd_rs !== held_rs) stab_bad <= stab_bad + 1;
      end
      if (done === 1'b1) done_cnt <= done_cnt + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int rd_ptr  = 0;

  task automatic check(input string nm, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [3:0] ra, input logic [15:0] val,
                              input logic [127:0] l1, input logic [47:0] tl, input logic [47:0] hx);
    vec_t v;
    v.op = op; v.ra = ra; v.val = val; v.line1 = l1; v.tail = tl; v.hex = hx;
    return v;
  endfunction

  task automatic push_init();
    exp_q.push_back('{1'b0, 8'h38});
    exp_q.push_back('{1'b0, 8'h0C});
    exp_q.push_back('{1'b0, 8'h06});
    exp_q.push_back('{1'b0, 8'h01});
  endtask

  task automatic push_update(input vec_t v);
    logic [7:0] ch;
    exp_q.push_back('{1'b0, 8'h80});
    for (int c = 0; c < 16; c++) exp_q.push_back('{1'b1, v.line1[8*(15-c) +: 8]});
    exp_q.push_back('{1'b0, 8'hC0});
    for (int c = 0; c < 16; c++) begin
      ch = 8'h20;
`ifdef LCD_DRIVER_HEX_EN
      if (c < 6) ch = v.hex[8*(5-c) +: 8];
`endif
      if (c >= 10) ch = v.tail[8*(15-c) +: 8];
      exp_q.push_back('{1'b1, ch});
    end
  endtask

  task automatic compare_captured(input string tag);
    xfer_t e;
    int k;
    check({tag, "_count"}, cap_n - rd_ptr, exp_q.size());
    k = 0;
    while (exp_q.size() > 0 && rd_ptr < cap_n) begin
      e = exp_q.pop_front();
      check($sformatf("%s_x%0d", tag, k), {cap_rs[rd_ptr], cap_data[rd_ptr]}, {e.rs, e.data});
      rd_ptr++;
      k++;
    end
    exp_q.delete();
    rd_ptr = cap_n;
  endtask

  task automatic wait_idle(input string nm, output int at);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy !== 1'b0 && k < 5000);
    at = cyc;
    check(nm, (busy === 1'b0) ? 1 : 0, 1);
  endtask

  // Reset release just after a rising edge makes monitor cycle N equal the
  // power-up counter value N: SETUP lands in cycle 16, en rises in cycle 17.
  // The clear command's HOLD is followed by 8 WAIT cycles, so busy is first
  // seen low 9 monitor cycles after the HOLD cycle.
  task automatic run_init(input string tag);
    int at;
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_init();
    wait_idle({tag, "_idle"}, at);
    check({tag, "_first_en"}, first_en, 17);
    check({tag, "_busy_fall"}, at - last_hold, 9);
    compare_captured(tag);
  endtask

  task automatic do_update(input vec_t v, input int inject, input string tag);
    int d0, k;
    d0 = done_cnt;
    @(negedge clk);
    req = 1'b1; opcode = v.op; reg_addr = v.ra; value = v.val;
    push_update(v);
    @(posedge clk);
    #1 check({tag, "_busy_acc"}, busy, 1);
    req = 1'b0; opcode = 3'($urandom); reg_addr = 4'($urandom); value = 16'($urandom);
    k = 0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 || k >= LAT + 50) break;
      if (inject > 0 && k == inject) begin
        req = 1'b1; opcode = ~v.op; reg_addr = ~v.ra; value = ~v.val;
      end else begin
        req = 1'b0;
      end
      k++;
    end
    req = 1'b0;
    check({tag, "_latency"}, k, LAT);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_once"}, done_cnt - d0, 1);
    compare_captured(tag);
    if (inject > 0) begin
      repeat (30) @(negedge clk);
      check({tag, "_no_second_done"}, done_cnt - d0, 1);
      check({tag, "_still_idle"}, busy, 0);
    end
  endtask

  initial begin
    int k;
    vecs[0] = mk(3'b001, 4'b0101, 16'd123,   "ADD   [0101]    ", "+00123", "0x007B");
    vecs[1] = mk(3'b011, 4'b0000, 16'h8000,  "SUB   [0000]    ", "-32768", "0x8000");
    vecs[2] = mk(3'b000, 4'b1111, 16'hFFFF,  "LOAD  [1111]    ", "-00001", "0xFFFF");
    vecs[3] = mk(3'b110, 4'b0010, 16'h0000,  "CLR   [0010]    ", "+00000", "0x0000");
    vecs[4] = mk(3'b010, 4'b1010, 16'h7FFF,  "ADDI  [1010]    ", "+32767", "0x7FFF");
    vecs[5] = mk(3'b100, 4'b0001, 16'h8001,  "SUBI  [0001]    ", "-32767", "0x8001");
    vecs[6] = mk(3'b101, 4'b1000, 16'hFF85,  "MUL   [1000]    ", "-00123", "0xFF85");
    vecs[7] = mk(3'b111, 4'b0110, 16'd1000,  "DPL   [0110]    ", "+01000", "0x03E8");

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_en",   lcd_en, 0);
    check("rst_rs",   lcd_rs, 0);
    check("rst_rw",   lcd_rw, 0);
    check("rst_data", lcd_data, 0);
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);

    run_init("init");

    for (int i = 0; i < NVEC; i++) do_update(vecs[i], 0, $sformatf("vec%0d", i));

    do_update(vecs[0], 100, "ignored_req");

    // Reset in the middle of a WRITE strobe.
    @(negedge clk);
    req = 1'b1; opcode = vecs[2].op; reg_addr = vecs[2].ra; value = vecs[2].val;
    @(posedge clk);
    #1 req = 1'b0;
    k = 0;
    while (!(lcd_en === 1'b1 && k > 40) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("midrst_en_before", lcd_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_en",   lcd_en, 0);
    check("midrst_data", lcd_data, 0);
    check("midrst_rs",   lcd_rs, 0);
    check("midrst_busy", busy, 1);
    check("midrst_done", done, 0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    rd_ptr = cap_n;
    run_init("reinit");
    do_update(vecs[0], 0, "post_rst");

    check("bus_stable_setup_to_hold", stab_bad, 0);
    check("total_done", done_cnt, NVEC + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
